// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the interrupt combiner/controller.
package irq_ctrl_pkg;

  localparam int MAX_SRC = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Width of a source index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set bit of vec wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8,
  localparam int W = id_w(N)
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);

  assign valid = |vec;

  // Scan from the top down so the last (lowest) hit is the one kept.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/irq_combiner_ctrl.sv
// Interrupt combiner: polarity/edge conditioning, pending latch, mask, and a
// single-outstanding req/ack/eoi handshake to the core. Define IRQ_SYNC_EN for input synchronizers.
module irq_combiner_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC     = 8,
  parameter logic [NUM_SRC-1:0] INVERT_MASK = '0,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
  localparam int                ID_W        = id_w(NUM_SRC)
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [NUM_SRC-1:0] Irq_in,
  input  logic               Mask_wr,
  input  logic [NUM_SRC-1:0] Mask_data,
  output logic [NUM_SRC-1:0] Irq_mask,
  output logic [NUM_SRC-1:0] Irq_pend,
  output logic               Irq_req,
  output logic [ID_W-1:0]    Irq_id,
  input  logic               Irq_ack,
  input  logic               Irq_eoi,
  output logic               In_service
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
    $error("irq_combiner_ctrl: NUM_SRC out of range 2..32");
  end

  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] real_in;
  logic [NUM_SRC-1:0] prev_reg;
  logic [NUM_SRC-1:0] pend_reg, pend_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] eligible;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_idx;
  logic               ack_take;

  irq_state_e      state_reg, state_next;
  logic            req_reg, req_next;
  logic [ID_W-1:0] id_reg, id_next;
  logic            svc_reg, svc_next;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= Irq_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_s = sync2_reg;
`else
  assign irq_s = Irq_in;
`endif

  assign real_in  = irq_s ^ INVERT_MASK;
  assign ack_take = (state_reg == REQ) && Irq_ack;

  // Edge sources: a new edge in the ack cycle beats the clear, so it is not lost.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    assign pend_next[gi] = EDGE_MASK[gi]
      ? ((real_in[gi] & ~prev_reg[gi]) |
         (pend_reg[gi] & ~(ack_take && (id_reg == ID_W'(gi)))))
      : real_in[gi];
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_reg <= '0;
      pend_reg <= '0;
      mask_reg <= '0;
    end else begin
      prev_reg <= real_in;
      pend_reg <= pend_next;
      if (Mask_wr) mask_reg <= Mask_data;
    end
  end

  assign eligible = pend_reg & mask_reg;

  irq_prio_enc #(
    .N(NUM_SRC)
  ) u_prio (
    .vec  (eligible),
    .valid(sel_valid),
    .idx  (sel_idx)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      id_reg    <= '0;
      svc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      id_reg    <= id_next;
      svc_reg   <= svc_next;
    end
  end

  // Id is captured once on entry to REQ and held until the next request.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    id_next    = id_reg;
    svc_next   = svc_reg;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          state_next = REQ;
          req_next   = 1'b1;
          id_next    = sel_idx;
        end
      end
      REQ: begin
        if (Irq_ack) begin
          state_next = SERVICE;
          req_next   = 1'b0;
          svc_next   = 1'b1;
        end
      end
      SERVICE: begin
        if (Irq_eoi) begin
          state_next = IDLE;
          svc_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
        svc_next   = 1'b0;
      end
    endcase
  end

  assign Irq_mask   = mask_reg;
  assign Irq_pend   = pend_reg;
  assign Irq_req    = req_reg;
  assign Irq_id     = id_reg;
  assign In_service = svc_reg;

endmodule

// File: tb/tb_irq_combiner_ctrl.sv
// Bench for irq_combiner_ctrl in its default (unsynchronised) build; source 0 is
// an inverted edge source, sources 1,2,5 are edge, the rest level.
module tb_irq_combiner_ctrl;

  typedef struct {
    logic [7:0] irq_in;
    logic       wr;
    logic [7:0] md;
    logic       ack;
    logic       eoi;
    logic [7:0] e_mask;
    logic [7:0] e_pend;
    logic       e_req;
    logic [2:0] e_id;
    logic       e_svc;
  } vec_t;

  logic       Clock;
  logic       Reset_n;
  logic [7:0] Irq_in;
  logic       Mask_wr;
  logic [7:0] Mask_data;
  logic [7:0] Irq_mask;
  logic [7:0] Irq_pend;
  logic       Irq_req;
  logic [2:0] Irq_id;
  logic       Irq_ack;
  logic       Irq_eoi;
  logic       In_service;

  int tests;
  int fails;
  vec_t exp_q[$];
  vec_t tbl[38];

  irq_combiner_ctrl #(
    .NUM_SRC    (8),
    .INVERT_MASK(8'h01),
    .EDGE_MASK  (8'h27)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Irq_in    (Irq_in),
    .Mask_wr   (Mask_wr),
    .Mask_data (Mask_data),
    .Irq_mask  (Irq_mask),
    .Irq_pend  (Irq_pend),
    .Irq_req   (Irq_req),
    .Irq_id    (Irq_id),
    .Irq_ack   (Irq_ack),
    .Irq_eoi   (Irq_eoi),
    .In_service(In_service)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic vec_t mk(input int i_in, input int wr, input int md, input int ack,
                              input int eoi, input int em, input int ep, input int er,
                              input int eid, input int es);
    vec_t v;
    v.irq_in = 8'(i_in);
    v.wr     = 1'(wr);
    v.md     = 8'(md);
    v.ack    = 1'(ack);
    v.eoi    = 1'(eoi);
    v.e_mask = 8'(em);
    v.e_pend = 8'(ep);
    v.e_req  = 1'(er);
    v.e_id   = 3'(eid);
    v.e_svc  = 1'(es);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Irq_in    = v.irq_in;
    Mask_wr   = v.wr;
    Mask_data = v.md;
    Irq_ack   = v.ack;
    Irq_eoi   = v.eoi;
    exp_q.push_back(v);
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, nothing expected", tag);
    end else begin
      e = exp_q.pop_front();
      if ({Irq_mask, Irq_pend, Irq_req, Irq_id, In_service} !==
          {e.e_mask, e.e_pend, e.e_req, e.e_id, e.e_svc}) begin
        fails++;
        $display("FAIL %s: got mask=%h pend=%h req=%b id=%0d svc=%b, want mask=%h pend=%h req=%b id=%0d svc=%b",
                 tag, Irq_mask, Irq_pend, Irq_req, Irq_id, In_service,
                 e.e_mask, e.e_pend, e.e_req, e.e_id, e.e_svc);
      end else begin
        $display("[TB] %s in=%h ack=%b eoi=%b -> mask=%h pend=%h req=%b id=%0d svc=%b ok",
                 tag, e.irq_in, e.ack, e.eoi, Irq_mask, Irq_pend, Irq_req, Irq_id, In_service);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(posedge Clock);
    @(negedge Clock);
    check_out(tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //              in    wr  md    ack eoi  mask  pend  req id svc
    // Pulse with mask=0 is ignored; then level source 3 with mask=FF
    tbl[0]  = mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(8'h09, 0, 8'h00, 0, 0, 8'h00, 8'h08, 0, 0, 0);
    tbl[2]  = mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[3]  = mk(8'h01, 1, 8'hFF, 0, 0, 8'hFF, 8'h00, 0, 0, 0);
    tbl[4]  = mk(8'h09, 0, 8'h00, 0, 0, 8'hFF, 8'h08, 0, 0, 0);
    tbl[5]  = mk(8'h09, 0, 8'h00, 0, 0, 8'hFF, 8'h08, 1, 3, 0);
    tbl[6]  = mk(8'h09, 0, 8'h00, 1, 0, 8'hFF, 8'h08, 0, 3, 1);
    tbl[7]  = mk(8'h09, 0, 8'h00, 0, 0, 8'hFF, 8'h08, 0, 3, 1);
    tbl[8]  = mk(8'h09, 0, 8'h00, 0, 1, 8'hFF, 8'h08, 0, 3, 0);
    tbl[9]  = mk(8'h09, 0, 8'h00, 0, 0, 8'hFF, 8'h08, 1, 3, 0);
    // eoi in REQ ignored, source drops and is masked: request and id held
    tbl[10] = mk(8'h01, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 1, 3, 0);
    tbl[11] = mk(8'h01, 1, 8'hF7, 0, 0, 8'hF7, 8'h00, 1, 3, 0);
    tbl[12] = mk(8'h01, 0, 8'h00, 1, 1, 8'hF7, 8'h00, 0, 3, 1);
    tbl[13] = mk(8'h01, 0, 8'h00, 0, 1, 8'hF7, 8'h00, 0, 3, 0);
    tbl[14] = mk(8'h01, 0, 8'h00, 1, 0, 8'hF7, 8'h00, 0, 3, 0);
    // Edge sources 5 and 2 together: 2 first, then 5
    tbl[15] = mk(8'h25, 0, 8'h00, 0, 0, 8'hF7, 8'h24, 0, 3, 0);
    tbl[16] = mk(8'h01, 0, 8'h00, 0, 0, 8'hF7, 8'h24, 1, 2, 0);
    tbl[17] = mk(8'h01, 0, 8'h00, 1, 0, 8'hF7, 8'h20, 0, 2, 1);
    tbl[18] = mk(8'h01, 0, 8'h00, 0, 1, 8'hF7, 8'h20, 0, 2, 0);
    tbl[19] = mk(8'h01, 0, 8'h00, 0, 0, 8'hF7, 8'h20, 1, 5, 0);
    tbl[20] = mk(8'h01, 0, 8'h00, 1, 0, 8'hF7, 8'h00, 0, 5, 1);
    tbl[21] = mk(8'h01, 0, 8'h00, 0, 1, 8'hF7, 8'h00, 0, 5, 0);
    tbl[22] = mk(8'h01, 0, 8'h00, 0, 0, 8'hF7, 8'h00, 0, 5, 0);
    // Inverted edge source 0: low pulse latches, second pulse in ack cycle survives
    tbl[23] = mk(8'h00, 0, 8'h00, 0, 0, 8'hF7, 8'h01, 0, 5, 0);
    tbl[24] = mk(8'h01, 0, 8'h00, 0, 0, 8'hF7, 8'h01, 1, 0, 0);
    tbl[25] = mk(8'h00, 0, 8'h00, 1, 0, 8'hF7, 8'h01, 0, 0, 1);
    tbl[26] = mk(8'h01, 0, 8'h00, 0, 0, 8'hF7, 8'h01, 0, 0, 1);
    tbl[27] = mk(8'h01, 0, 8'h00, 0, 1, 8'hF7, 8'h01, 0, 0, 0);
    tbl[28] = mk(8'h01, 0, 8'h00, 0, 0, 8'hF7, 8'h01, 1, 0, 0);
    tbl[29] = mk(8'h01, 0, 8'h00, 1, 0, 8'hF7, 8'h00, 0, 0, 1);
    tbl[30] = mk(8'h01, 0, 8'h00, 0, 1, 8'hF7, 8'h00, 0, 0, 0);
    // Masked pending edge stays latched, request two cycles after mask write
    tbl[31] = mk(8'h01, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[32] = mk(8'h03, 0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0, 0);
    tbl[33] = mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0, 0);
    tbl[34] = mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0, 0);
    tbl[35] = mk(8'h01, 1, 8'h02, 0, 0, 8'h02, 8'h02, 0, 0, 0);
    tbl[36] = mk(8'h01, 0, 8'h00, 0, 0, 8'h02, 8'h02, 1, 1, 0);
    tbl[37] = mk(8'h01, 0, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 1);

    Reset_n = 1'b0;
    drive(mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    repeat (2) @(negedge Clock);
    check_out("reset_state");
    Reset_n = 1'b1;

    for (int i = 0; i < 38; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // DUT is now mid-SERVICE; reset asserts between edges and must act at once
    #2;
    Reset_n = 1'b0;
    #1;
    drive(mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    check_out("async_reset");
    @(negedge Clock);
    Reset_n = 1'b1;

    apply(mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0), "post_rst_idle");
    apply(mk(8'h09, 0, 8'h00, 0, 0, 8'h00, 8'h08, 0, 0, 0), "post_rst_masked");
    apply(mk(8'h09, 1, 8'h08, 0, 0, 8'h08, 8'h08, 0, 0, 0), "post_rst_mask_wr");
    apply(mk(8'h09, 0, 8'h00, 0, 0, 8'h08, 8'h08, 1, 3, 0), "post_rst_req");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
